// File: rtl/video_ce_synth.sv
// Multi-channel clock-enable synthesiser: one phase accumulator per channel on refclk,
// one-cycle ce pulse per accumulator carry, runtime retune with per-channel lock tracking.
module video_ce_synth #(
    parameter int              NUM_CH      = 2,
    parameter int              ACC_W       = 32,
    parameter longint unsigned DEFAULT_INC = 64'd2162571354,
    parameter int              LOCK_PULSES = 16,
    parameter int              CH_W        = 1
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [ACC_W-1:0]      cfg_inc,
    output logic                  cfg_err,
    output logic [NUM_CH-1:0]     ce_out,
    output logic [NUM_CH-1:0]     locked,
    output logic [2*NUM_CH-1:0]   dbg_state
);

    // Handshake: a retune transfers on a rising edge where cfg_valid & cfg_ready are both 1;
    // cfg_ready is then low for exactly one cycle, so accepts are spaced at least two cycles.

    localparam int              CNT_W    = $clog2(LOCK_PULSES + 1);
    localparam logic [CH_W:0]   NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [ACC_W-1:0] RST_INC = ACC_W'(DEFAULT_INC);

    typedef enum logic [1:0] {
        ST_SETTLING = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_STOPPED  = 2'd2
    } ch_state_e;

    logic [ACC_W-1:0] acc_q [NUM_CH];
    logic [ACC_W-1:0] acc_d [NUM_CH];
    logic [ACC_W-1:0] inc_q [NUM_CH];
    logic [ACC_W-1:0] inc_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    ch_state_e        state_q [NUM_CH];
    ch_state_e        state_d [NUM_CH];
    logic [NUM_CH-1:0] ce_q, ce_d;
    logic [NUM_CH-1:0] locked_q, locked_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;

    logic             accept;
    logic             ch_in_range;
    logic [ACC_W:0]   sum;

    always_comb begin
        accept      = cfg_valid & ready_q;
        ch_in_range = ({1'b0, cfg_ch} < NUM_CH_L);
        ready_d     = ~accept;
        err_d       = accept & ~ch_in_range;
        acc_d       = acc_q;
        inc_d       = inc_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        ce_d        = '0;
        locked_d    = locked_q;
        sum         = '0;

        for (int c = 0; c < NUM_CH; c++) begin
            sum = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
            if (accept && ch_in_range && (cfg_ch == CH_W'(c))) begin
                // Retune restarts phase and lock; a carry on this edge is dropped.
                acc_d[c]    = '0;
                inc_d[c]    = cfg_inc;
                cnt_d[c]    = '0;
                locked_d[c] = 1'b0;
                state_d[c]  = (cfg_inc == '0) ? ST_STOPPED : ST_SETTLING;
            end else if (state_q[c] == ST_STOPPED) begin
                acc_d[c]    = '0;
                locked_d[c] = 1'b0;
            end else begin
                acc_d[c] = sum[ACC_W-1:0];
                ce_d[c]  = sum[ACC_W];
                if (state_q[c] == ST_SETTLING && sum[ACC_W]) begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                    if (cnt_q[c] == CNT_W'(LOCK_PULSES - 1)) begin
                        locked_d[c] = 1'b1;
                        state_d[c]  = ST_LOCKED;
                    end
                end
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c]   <= '0;
                inc_q[c]   <= RST_INC;
                cnt_q[c]   <= '0;
                state_q[c] <= ST_SETTLING;
            end
            ce_q     <= '0;
            locked_q <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            inc_q    <= inc_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            ce_q     <= ce_d;
            locked_q <= locked_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            dbg_state[2*c +: 2] = state_q[c];
        end
    end

    assign ce_out    = ce_q;
    assign locked    = locked_q;
    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_video_ce_synth.sv
// Bench for video_ce_synth: ce/lock expectations come from the closed form
// pulses(j) = floor(j*inc / 2**32), j = edges since the last retune or reset release.
module tb_video_ce_synth;

    localparam int              NUM_CH      = 2;
    localparam int              ACC_W       = 32;
    localparam int              CH_W        = 2;
    localparam int              LOCK_PULSES = 16;
    localparam longint unsigned DEF_INC     = 64'd2162571354;

    logic                refclk;
    logic                rst_n;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch;
    logic [ACC_W-1:0]    cfg_inc;
    logic                cfg_err;
    logic [NUM_CH-1:0]   ce_out;
    logic [NUM_CH-1:0]   locked;
    logic [2*NUM_CH-1:0] dbg_state;

    video_ce_synth #(
        .NUM_CH(NUM_CH), .ACC_W(ACC_W), .DEFAULT_INC(DEF_INC),
        .LOCK_PULSES(LOCK_PULSES), .CH_W(CH_W)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_err(cfg_err), .ce_out(ce_out),
        .locked(locked), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    // ---------------- reference model ----------------
    longint unsigned jcnt [NUM_CH];
    longint unsigned minc [NUM_CH];
    bit              in_reset;
    bit              exp_ready;
    bit              exp_err;
    int              n_acc;
    int              n_pass;
    int              n_total;

    function automatic longint unsigned pulses(int c, longint unsigned j);
        return (j * minc[c]) >> 32;
    endfunction

    function automatic logic exp_ce(int c);
        if (in_reset || minc[c] == 0 || jcnt[c] == 0) return 1'b0;
        return pulses(c, jcnt[c]) != pulses(c, jcnt[c] - 1);
    endfunction

    function automatic logic exp_locked(int c);
        if (in_reset || minc[c] == 0) return 1'b0;
        return pulses(c, jcnt[c]) >= LOCK_PULSES;
    endfunction

    function automatic logic [5:0] exp_vec();
        return {exp_ce(1), exp_ce(0), exp_locked(1), exp_locked(0),
                exp_ready & ~in_reset, exp_err & ~in_reset};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            jcnt[c] = 0;
            minc[c] = DEF_INC;
        end
        exp_ready = 1'b0;
        exp_err   = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // One rising edge for DUT and model; returns 1 time unit after the edge.
    task automatic tick();
        bit acc;
        acc = cfg_valid && exp_ready && !in_reset;
        @(posedge refclk);
        if (!in_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc && int'(cfg_ch) == c) begin
                    jcnt[c] = 0;
                    minc[c] = longint'(cfg_inc);
                end else begin
                    jcnt[c]++;
                end
            end
            exp_err   = acc && (cfg_ch >= CH_W'(NUM_CH));
            exp_ready = !acc;
            if (acc) n_acc++;
        end
        #1;
    endtask

    // Presents a request and holds it until the accept edge has happened.
    task automatic do_cfg(input logic [CH_W-1:0] ch, input logic [ACC_W-1:0] inc);
        cfg_ch    = ch;
        cfg_inc   = inc;
        cfg_valid = 1'b1;
        for (int k = 0; k < 4 && !exp_ready; k++) tick();
        tick();
        cfg_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_reset  = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_inc   = '0;
        model_reset();
        repeat (3) @(posedge refclk);
        #3;
        n_total++;
        if ({ce_out, locked, cfg_ready, cfg_err} !== 6'b0)
            $display("FAIL reset_hold: got %b exp %b", {ce_out, locked, cfg_ready, cfg_err}, 6'b0);
        else n_pass++;
        rst_n    = 1'b1;
        in_reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n_total++;
            if ({ce_out, locked, cfg_ready, cfg_err} !== exp_vec())
                $display("FAIL reset_run cyc %0d: got %b exp %b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (locked !== 2'b11) $display("FAIL default_lock: got %b exp 11", locked);
        else n_pass++;
    endtask

    task automatic test_quarter_rate();
        int seen;
        seen = 0;
        repeat ($urandom_range(1, 5)) tick();
        do_cfg(0, 32'h4000_0000);
        n_total++;
        if ({ce_out, locked, cfg_ready, cfg_err} !== exp_vec() || locked[0] !== 1'b0)
            $display("FAIL quarter_accept: got %b exp %b", {ce_out, locked, cfg_ready, cfg_err}, exp_vec());
        else n_pass++;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (i < 40) seen += int'(ce_out[0]);
            n_total++;
            if ({ce_out, locked, cfg_ready, cfg_err} !== exp_vec())
                $display("FAIL quarter_run cyc %0d: got %b exp %b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (seen !== 10) $display("FAIL quarter_count: got %0d exp 10", seen);
        else n_pass++;
    endtask

    task automatic test_stop_restart();
        int seen;
        seen = 0;
        do_cfg(1, 32'h0);
        for (int i = 0; i < 40; i++) begin
            tick();
            seen += int'(ce_out[1]) + int'(locked[1]);
            n_total++;
            if ({ce_out, locked, cfg_ready, cfg_err} !== exp_vec())
                $display("FAIL stop_run cyc %0d: got %b exp %b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL stop_quiet: got %0d exp 0", seen);
        else n_pass++;
        do_cfg(1, 32'h8000_0000);
        for (int i = 0; i < 40; i++) begin
            tick();
            n_total++;
            if ({ce_out, locked, cfg_ready, cfg_err} !== exp_vec())
                $display("FAIL restart_run cyc %0d: got %b exp %b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (locked[1] !== 1'b1) $display("FAIL restart_lock: got %b exp 1", locked[1]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int start_acc;
        cfg_valid = 1'b0;
        tick();
        tick();
        start_acc = n_acc;
        cfg_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cfg_ch  = CH_W'($urandom_range(0, 1));
            cfg_inc = $urandom_range(1, 32'hFFFF_FFFF);
            tick();
            n_total++;
            if ({ce_out, locked, cfg_ready, cfg_err} !== exp_vec())
                $display("FAIL b2b cyc %0d: got %b exp %b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_vec());
            else n_pass++;
        end
        cfg_valid = 1'b0;
        n_total++;
        if (n_acc - start_acc !== 5) $display("FAIL b2b_accepts: got %0d exp 5", n_acc - start_acc);
        else n_pass++;
    endtask

    task automatic test_bad_channel();
        logic [NUM_CH-1:0] lk_before;
        repeat (40) tick();
        lk_before = locked;
        do_cfg(3, 32'h1234_5678);
        n_total++;
        if ({ce_out, locked, cfg_ready, cfg_err} !== exp_vec() || cfg_err !== 1'b1 || locked !== lk_before)
            $display("FAIL badch_err: got %b exp %b", {ce_out, locked, cfg_ready, cfg_err}, exp_vec());
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_total++;
            if ({ce_out, locked, cfg_ready, cfg_err} !== exp_vec())
                $display("FAIL badch_run cyc %0d: got %b exp %b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       cfg_inc = 32'h0;
                1:       cfg_inc = 32'hFFFF_FFFF;
                2:       cfg_inc = 32'h8000_0000;
                3:       cfg_inc = $urandom_range(1, 32'h0FFF_FFFF);
                default: cfg_inc = $urandom;
            endcase
            tick();
            n_total++;
            if ({ce_out, locked, cfg_ready, cfg_err} !== exp_vec())
                $display("FAIL random cyc %0d: got %b exp %b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_vec());
            else n_pass++;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_cfg(0, 32'h4000_0000);
        repeat (20) tick();
        #2;
        rst_n    = 1'b0;
        in_reset = 1'b1;
        #1;
        n_total++;
        if ({ce_out, locked, cfg_ready, cfg_err} !== 6'b0)
            $display("FAIL async_reset: got %b exp %b", {ce_out, locked, cfg_ready, cfg_err}, 6'b0);
        else n_pass++;
        rst_n    = 1'b1;
        in_reset = 1'b0;
        model_reset();
        for (int i = 0; i < 50; i++) begin
            tick();
            n_total++;
            if ({ce_out, locked, cfg_ready, cfg_err} !== exp_vec())
                $display("FAIL post_reset cyc %0d: got %b exp %b", i, {ce_out, locked, cfg_ready, cfg_err}, exp_vec());
            else n_pass++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_pass  = 0;
        n_total = 0;
        n_acc   = 0;
        test_reset();
        test_quarter_rate();
        test_stop_restart();
        test_back_to_back();
        test_bad_channel();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
